vx_pending_instr_tracker: RTL and testbench
===========================================

// Module: vx_pending_instr_tracker
// PURPOSE
//  Per-warp in-flight instruction counter feeding the CSR unit's sched_csr_if alm_empty/alm_empty_wid pair.
//  Counts instructions issued but not yet committed (eop) per warp, so FPU-CSR accesses can wait for warp drain.
//  Sits in the scheduler: issue events arrive from the issue stage, retire events from all commit lanes.
//  Also exports a per-warp pending mask for fences/barriers.
// PARAMETERS
//  NUM_WARPS   `NUM_WARPS  number of warps tracked
//  ISSUE_W     1           issue events accepted per cycle
//  COMMIT_W    `NUM_EX_UNITS commit lanes observed per cycle
//  CTR_W       6           counter width per warp; max in-flight per warp = 2^CTR_W-1
//  ALM_EMPTY   1           alm_empty threshold (the querying CSR instr itself is counted)
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 synchronous, active-high reset
//  issue_valid    in   ISSUE_W           issue fire (valid&&ready) per slot
//  issue_wid      in   ISSUE_W*NW_WIDTH  warp id per issue slot
//  commit_valid   in   COMMIT_W          commit fire (valid&&ready) per lane
//  commit_wid     in   COMMIT_W*NW_WIDTH warp id per commit lane
//  commit_eop     in   COMMIT_W          last packet of instruction; only eop retires
//  alm_empty_wid  in   NW_WIDTH          queried warp (from CSR unit)
//  alm_empty      out  1                 count[alm_empty_wid] <= ALM_EMPTY
//  pending_mask   out  NUM_WARPS         bit w = count[w] != 0
//  overflow       out  1                 sticky error: increment at max or decrement at 0
// BEHAVIOUR
//  - State: cnt[NUM_WARPS][CTR_W], registered; overflow flop. Reset: all cnt=0, overflow=0,
//    hence pending_mask=0, alm_empty=1 after reset for every wid.
//  - Per cycle, per warp w: inc_w = popcount(issue_valid[i] && issue_wid[i]==w);
//    dec_w = popcount(commit_valid[j] && commit_eop[j] && commit_wid[j]==w);
//    cnt_next = cnt + inc_w - dec_w, computed at CTR_W+2 bits signed, then truncated.
//  - Simultaneous inc and dec on the same warp apply as net delta (issue+commit same cycle = unchanged).
//  - Non-eop commit packets never change cnt.
//  - Underflow (cnt+inc<dec) or overflow (result > 2^CTR_W-1): cnt saturates (0 / max),
//    overflow set next cycle and held until reset; simulation assertion fires.
//  - Latency: events update cnt 1 cycle after fire. alm_empty and pending_mask are combinational
//    reads of registered cnt (same-cycle wid lookup, no added cycle) so CSR unit handshake is unaffected.
//  - alm_empty_wid >= NUM_WARPS: alm_empty=1 (out-of-range treated as empty).
//  - Reset mid-operation: all counts cleared next edge; in-flight commits arriving after reset
//    while cnt=0 are underflow (upstream must flush with reset).
//  - No backpressure: block is always ready; it only observes fires.
// STRUCTURE
//  - Shared package (VX_gpu_pkg): NW_WIDTH use only; add PENDING_CTR_W localparam default.
//  - One sub-module: vx_pending_ctr (single up/down saturating counter, inputs inc/dec counts,
//    outputs cnt, is_zero, err); instantiated NUM_WARPS times via generate.
//  - Top level: decode/popcount per warp, alm_empty mux, overflow OR-reduce + sticky flop.
// TESTING
//  1 reset -> all pending_mask=0, alm_empty=1 for wid 0..NUM_WARPS-1, overflow=0.
//  2 issue wid2 x3 cycles, query wid2 -> cnt=3, alm_empty=0; commit eop wid2 x2 -> alm_empty=1, mask[2]=1.
//  3 same cycle issue wid1 + commit eop wid1 (cnt=1) -> cnt stays 1; commit non-eop wid1 -> unchanged.
//  4 COMMIT_W=3 lanes all eop wid0 at cnt=3 -> cnt=0 next cycle, mask[0]=0.
//  5 commit eop wid5 at cnt=0 -> cnt stays 0, overflow=1 and stays 1 until reset.
//  6 issue wid7 2^CTR_W times without commit -> cnt saturates 63, overflow=1; reset mid-burst -> cnt=0.
//  Random: scoreboard model of issue/commit streams, compare cnt/alm_empty every cycle.

Source files
------------

// File: rtl/vx_pending_instr_tracker_pkg.sv
// ----------------------------------------------------------------------------
// vx_pending_instr_tracker_pkg
// Shared constants for the pending-instruction tracker: default warp count,
// lane counts, warp-id width and the per-warp counter width, plus width
// helpers used by the interface, the top level and the counter.
// ----------------------------------------------------------------------------
package vx_pending_instr_tracker_pkg;

    // Width of a warp id; a single warp still needs a one-bit id.
    function automatic int calc_nw_width(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

    // Width needed to hold a population count of 0..n.
    function automatic int calc_cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    localparam int DEF_NUM_WARPS    = 8;
    localparam int DEF_NUM_EX_UNITS = 3;
    localparam int DEF_ISSUE_W      = 1;
    localparam int DEF_COMMIT_W     = DEF_NUM_EX_UNITS;
    localparam int NW_WIDTH         = calc_nw_width(DEF_NUM_WARPS);
    localparam int PENDING_CTR_W    = 6;
    // The CSR instruction asking the question is itself in flight.
    localparam int DEF_ALM_EMPTY    = 1;

endpackage

// File: rtl/vx_pending_instr_tracker_if.sv
// ----------------------------------------------------------------------------
// vx_pending_instr_tracker_if
// Groups the observed issue/commit fires and the CSR-facing query/status
// signals of the pending-instruction tracker.
//   issue_valid/issue_wid           : issue fires and their warp ids
//   commit_valid/commit_wid/_eop    : commit fires per lane; only eop retires
//   alm_empty_wid -> alm_empty      : combinational almost-empty query
//   pending_mask, overflow          : per-warp busy mask, sticky error
// master: the scheduler side driving events; slave: the tracker.
// ----------------------------------------------------------------------------
interface vx_pending_instr_tracker_if #(
    parameter int NUM_WARPS = vx_pending_instr_tracker_pkg::DEF_NUM_WARPS,
    parameter int ISSUE_W   = vx_pending_instr_tracker_pkg::DEF_ISSUE_W,
    parameter int COMMIT_W  = vx_pending_instr_tracker_pkg::DEF_COMMIT_W
);
    localparam int NW = vx_pending_instr_tracker_pkg::calc_nw_width(NUM_WARPS);

    logic [ISSUE_W-1:0]       issue_valid;
    logic [ISSUE_W*NW-1:0]    issue_wid;
    logic [COMMIT_W-1:0]      commit_valid;
    logic [COMMIT_W*NW-1:0]   commit_wid;
    logic [COMMIT_W-1:0]      commit_eop;
    logic [NW-1:0]            alm_empty_wid;
    logic                     alm_empty;
    logic [NUM_WARPS-1:0]     pending_mask;
    logic                     overflow;

    modport master (
        output issue_valid, issue_wid, commit_valid, commit_wid, commit_eop,
        output alm_empty_wid,
        input  alm_empty, pending_mask, overflow
    );

    modport slave (
        input  issue_valid, issue_wid, commit_valid, commit_wid, commit_eop,
        input  alm_empty_wid,
        output alm_empty, pending_mask, overflow
    );

endinterface

// File: rtl/vx_pending_ctr.sv
// ----------------------------------------------------------------------------
// vx_pending_ctr
// Single saturating up/down counter of in-flight instructions for one warp.
//   clk, reset : clock, synchronous active-high reset (clears the count)
//   inc_i      : number of issues to this warp this cycle
//   dec_i      : number of eop commits of this warp this cycle
//   cnt_o      : registered count
//   is_zero_o  : count == 0
//   err_o      : this cycle's update would under- or overflow (count saturates)
// ----------------------------------------------------------------------------
module vx_pending_ctr #(
    parameter int CTR_W = 6,
    parameter int INC_W = 1,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] inc_i,
    input  logic [DEC_W-1:0] dec_i,
    output logic [CTR_W-1:0] cnt_o,
    output logic             is_zero_o,
    output logic             err_o
);
    // Two guard bits: the MSB acts as a sign (underflow), the next one as
    // a carry past the maximum count (overflow).
    localparam int SW = CTR_W + 2;

    logic [CTR_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    sum;
    logic             under, over;

    always_comb begin
        sum   = SW'(cnt_q) + SW'(inc_i) - SW'(dec_i);
        under = sum[SW-1];
        over  = !sum[SW-1] && sum[CTR_W];
        if (under) begin
            cnt_d = '0;
        end else if (over) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[CTR_W-1:0];
        end
        err_o = under || over;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/vx_pending_instr_tracker.sv
// ----------------------------------------------------------------------------
// vx_pending_instr_tracker
// Per-warp count of instructions issued but not yet retired (eop commit).
// Feeds the CSR unit's almost-empty query and exports a pending mask for
// fences/barriers. Always ready: it only observes fires.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of vx_pending_instr_tracker_if
//                (issue/commit fires in, alm_empty/pending_mask/overflow out)
// Counts update one cycle after the fire; alm_empty and pending_mask are
// combinational reads of the registered counts.
// ----------------------------------------------------------------------------
module vx_pending_instr_tracker
    import vx_pending_instr_tracker_pkg::*;
#(
    parameter int NUM_WARPS  = DEF_NUM_WARPS,
    parameter int ISSUE_W    = DEF_ISSUE_W,
    parameter int COMMIT_W   = DEF_COMMIT_W,
    parameter int CTR_W      = PENDING_CTR_W,
    parameter int ALM_EMPTY  = DEF_ALM_EMPTY,
    parameter bit ERR_ASSERT = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    vx_pending_instr_tracker_if.slave    bus
);
    localparam int NW      = calc_nw_width(NUM_WARPS);
    localparam int IW      = calc_cnt_width(ISSUE_W);
    localparam int DW      = calc_cnt_width(COMMIT_W);
    localparam int NW_SPAN = 1 << NW;

    logic [CTR_W-1:0]     cnt_w [NUM_WARPS];
    logic [NUM_WARPS-1:0] zero_w;
    logic [NUM_WARPS-1:0] err_w;
    logic [NW_SPAN-1:0]   ae_vec;
    logic                 overflow_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [IW-1:0] inc;
            logic [DW-1:0] dec;

            // Decode every slot/lane against this warp and popcount the hits.
            always_comb begin
                inc = '0;
                for (int i = 0; i < ISSUE_W; i++) begin
                    if (bus.issue_valid[i] && (bus.issue_wid[i*NW +: NW] == NW'(gi))) begin
                        inc = inc + IW'(1);
                    end
                end
            end

            always_comb begin
                dec = '0;
                for (int j = 0; j < COMMIT_W; j++) begin
                    if (bus.commit_valid[j] && bus.commit_eop[j]
                        && (bus.commit_wid[j*NW +: NW] == NW'(gi))) begin
                        dec = dec + DW'(1);
                    end
                end
            end

            vx_pending_ctr #(
                .CTR_W (CTR_W),
                .INC_W (IW),
                .DEC_W (DW)
            ) u_ctr (
                .clk       (clk),
                .reset     (reset),
                .inc_i     (inc),
                .dec_i     (dec),
                .cnt_o     (cnt_w[gi]),
                .is_zero_o (zero_w[gi]),
                .err_o     (err_w[gi])
            );
        end

        // Query table padded to the full id space so ids beyond the last
        // warp read as empty without a range compare.
        for (gi = 0; gi < NW_SPAN; gi++) begin : g_ae
            if (gi < NUM_WARPS) begin : g_real
                assign ae_vec[gi] = (cnt_w[gi] <= CTR_W'(ALM_EMPTY));
            end else begin : g_pad
                assign ae_vec[gi] = 1'b1;
            end
        end
    endgenerate

    assign bus.alm_empty    = ae_vec[bus.alm_empty_wid];
    assign bus.pending_mask = ~zero_w;
    assign bus.overflow     = overflow_q;

    // Sticky until reset so software can find out after the fact.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (|err_w) begin
            overflow_q <= 1'b1;
        end
    end

    generate
        if (ERR_ASSERT) begin : g_assert
            a_no_ctr_err : assert property (@(posedge clk) disable iff (reset) err_w == '0);
        end
    endgenerate

endmodule

// File: tb/tb_vx_pending_instr_tracker.sv
// ----------------------------------------------------------------------------
// tb_vx_pending_instr_tracker
// Table-driven directed vectors, hand-written saturation/reset sequences and
// a random phase, all checked against a scoreboard of per-warp counts.
// ----------------------------------------------------------------------------
module tb_vx_pending_instr_tracker;
    import vx_pending_instr_tracker_pkg::*;

    localparam int NWARP = DEF_NUM_WARPS;
    localparam int IW    = DEF_ISSUE_W;
    localparam int CW    = DEF_COMMIT_W;
    localparam int NWW   = NW_WIDTH;
    localparam int MAXC  = (1 << PENDING_CTR_W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #20 clk = ~clk;

    vx_pending_instr_tracker_if #(
        .NUM_WARPS (NWARP),
        .ISSUE_W   (IW),
        .COMMIT_W  (CW)
    ) bus ();

    vx_pending_instr_tracker #(
        .NUM_WARPS  (NWARP),
        .ISSUE_W    (IW),
        .COMMIT_W   (CW),
        .CTR_W      (PENDING_CTR_W),
        .ALM_EMPTY  (DEF_ALM_EMPTY),
        .ERR_ASSERT (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic                  ovf;
        logic [NWARP-1:0][6:0] cnt;
    } exp_t;

    typedef struct {
        logic               iv;
        logic [NWW-1:0]     iw;
        logic [CW-1:0]      cv;
        logic [CW*NWW-1:0]  cw;
        logic [CW-1:0]      ce;
        logic [NWW-1:0]     qwid;
        logic               ae;
        logic [NWARP-1:0]   mask;
        logic               ovf;
    } vec_t;

    exp_t sb_q[$];
    int   mcnt [NWARP];
    bit   movf;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    vec_t vecs [15];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_step(input bit rst, input logic iv, input logic [NWW-1:0] iw,
                              input logic [CW-1:0] cv, input logic [CW*NWW-1:0] cw,
                              input logic [CW-1:0] ce);
        exp_t e;
        if (rst) begin
            for (int w = 0; w < NWARP; w++) mcnt[w] = 0;
            movf = 1'b0;
        end else begin
            for (int w = 0; w < NWARP; w++) begin
                int s;
                s = mcnt[w];
                if (iv && (int'(iw) == w)) s = s + 1;
                for (int j = 0; j < CW; j++) begin
                    if (cv[j] && ce[j] && (int'(cw[j*NWW +: NWW]) == w)) s = s - 1;
                end
                if (s < 0) begin
                    s = 0;
                    movf = 1'b1;
                end else if (s > MAXC) begin
                    s = MAXC;
                    movf = 1'b1;
                end
                mcnt[w] = s;
            end
        end
        e.ovf = movf;
        for (int w = 0; w < NWARP; w++) e.cnt[w] = 7'(mcnt[w]);
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        logic [NWARP-1:0] m;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        m = '0;
        for (int w = 0; w < NWARP; w++) begin
            bus.alm_empty_wid = NWW'(w);
            #1;
            chk($sformatf("alm_empty_w%0d", w), int'(bus.alm_empty), int'(e.cnt[w] <= 7'd1));
            m[w] = (e.cnt[w] != 7'd0);
        end
        chk("pending_mask", int'(bus.pending_mask), int'(m));
        chk("overflow", int'(bus.overflow), int'(e.ovf));
    endtask

    // One transaction = one clock of observed fires (and optional reset).
    task automatic drive(input bit rst, input logic iv, input logic [NWW-1:0] iw,
                         input logic [CW-1:0] cv, input logic [CW*NWW-1:0] cw,
                         input logic [CW-1:0] ce);
        reset            = rst;
        bus.issue_valid  = iv;
        bus.issue_wid    = iw;
        bus.commit_valid = cv;
        bus.commit_wid   = cw;
        bus.commit_eop   = ce;
        model_step(rst, iv, iw, cv, cw, ce);
        @(posedge clk);
        #1;
        cyc++;
        sb_check();
        $display("cyc %0d rst=%0b iss=%0b/w%0d cv=%b cw=%h ce=%b -> mask=%h ovf=%0b",
                 cyc, rst, iv, iw, cv, cw, ce, bus.pending_mask, bus.overflow);
    endtask

    task automatic idle(input bit rst);
        drive(rst, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        // Directed vectors; expectations hand-derived from the count sequence.
        //            iv    iw    cv      cw                     ce      q     ae    mask    ovf
        vecs[0]  = '{1'b1, 3'd2, 3'b000, {3'd0, 3'd0, 3'd0}, 3'b000, 3'd2, 1'b1, 8'h04, 1'b0};
        vecs[1]  = '{1'b1, 3'd2, 3'b000, {3'd0, 3'd0, 3'd0}, 3'b000, 3'd2, 1'b0, 8'h04, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 3'b000, {3'd0, 3'd0, 3'd0}, 3'b000, 3'd2, 1'b0, 8'h04, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 3'b001, {3'd0, 3'd0, 3'd2}, 3'b001, 3'd2, 1'b0, 8'h04, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 3'b001, {3'd0, 3'd0, 3'd2}, 3'b001, 3'd2, 1'b1, 8'h04, 1'b0};
        vecs[5]  = '{1'b1, 3'd1, 3'b000, {3'd0, 3'd0, 3'd0}, 3'b000, 3'd1, 1'b1, 8'h06, 1'b0};
        vecs[6]  = '{1'b1, 3'd1, 3'b010, {3'd0, 3'd1, 3'd0}, 3'b010, 3'd1, 1'b1, 8'h06, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 3'b001, {3'd0, 3'd0, 3'd1}, 3'b000, 3'd1, 1'b1, 8'h06, 1'b0};
        vecs[8]  = '{1'b1, 3'd0, 3'b000, {3'd0, 3'd0, 3'd0}, 3'b000, 3'd0, 1'b1, 8'h07, 1'b0};
        vecs[9]  = '{1'b1, 3'd0, 3'b000, {3'd0, 3'd0, 3'd0}, 3'b000, 3'd0, 1'b0, 8'h07, 1'b0};
        vecs[10] = '{1'b1, 3'd0, 3'b000, {3'd0, 3'd0, 3'd0}, 3'b000, 3'd0, 1'b0, 8'h07, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 3'b111, {3'd0, 3'd0, 3'd0}, 3'b111, 3'd0, 1'b1, 8'h06, 1'b0};
        vecs[12] = '{1'b1, 3'd3, 3'b001, {3'd0, 3'd0, 3'd2}, 3'b001, 3'd3, 1'b1, 8'h0A, 1'b0};
        vecs[13] = '{1'b0, 3'd0, 3'b100, {3'd5, 3'd0, 3'd0}, 3'b100, 3'd5, 1'b1, 8'h0A, 1'b1};
        vecs[14] = '{1'b0, 3'd0, 3'b000, {3'd0, 3'd0, 3'd0}, 3'b000, 3'd5, 1'b1, 8'h0A, 1'b1};

        for (int w = 0; w < NWARP; w++) mcnt[w] = 0;
        movf = 1'b0;
        reset = 1'b1;
        bus.issue_valid = '0;
        bus.issue_wid = '0;
        bus.commit_valid = '0;
        bus.commit_wid = '0;
        bus.commit_eop = '0;
        bus.alm_empty_wid = '0;

        // Reset state: every warp empty, nothing pending, no error.
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        for (int k = 0; k < 15; k++) begin
            drive(1'b0, vecs[k].iv, vecs[k].iw, vecs[k].cv, vecs[k].cw, vecs[k].ce);
            bus.alm_empty_wid = vecs[k].qwid;
            #1;
            chk($sformatf("vec%0d_alm_empty", k), int'(bus.alm_empty), int'(vecs[k].ae));
            chk($sformatf("vec%0d_mask", k), int'(bus.pending_mask), int'(vecs[k].mask));
            chk($sformatf("vec%0d_overflow", k), int'(bus.overflow), int'(vecs[k].ovf));
        end

        // Saturation on warp 7: 63 issues are legal, the 64th overflows.
        idle(1'b1);
        for (int k = 0; k < MAXC; k++) drive(1'b0, 1'b1, 3'd7, '0, '0, '0);
        chk("sat_no_ovf_at_max", int'(bus.overflow), 0);
        drive(1'b0, 1'b1, 3'd7, '0, '0, '0);
        chk("sat_ovf_set", int'(bus.overflow), 1);
        // Held at 63, not wrapped: 20 triple retires leave 3 pending.
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b0, '0, 3'b111, {3'd7, 3'd7, 3'd7}, 3'b111);
        chk("sat_held_mask7", int'(bus.pending_mask[7]), 1);
        drive(1'b0, 1'b0, '0, 3'b111, {3'd7, 3'd7, 3'd7}, 3'b111);
        chk("sat_drained_mask7", int'(bus.pending_mask[7]), 0);
        chk("sat_ovf_sticky", int'(bus.overflow), 1);

        // Reset in the middle of an issue burst clears everything.
        idle(1'b1);
        for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 3'd7, '0, '0, '0);
        drive(1'b1, 1'b1, 3'd7, '0, '0, '0);
        idle(1'b0);
        chk("midreset_mask", int'(bus.pending_mask), 0);
        chk("midreset_ovf", int'(bus.overflow), 0);
        bus.alm_empty_wid = 3'd7;
        #1;
        chk("midreset_ae7", int'(bus.alm_empty), 1);

        // Random issue/commit traffic on a few warps.
        for (int n = 0; n < 200; n++) begin
            logic              iv;
            logic [NWW-1:0]    iw;
            logic [CW-1:0]     cv, ce;
            logic [CW*NWW-1:0] cw;
            iv = ($urandom_range(0, 9) < 7);
            iw = NWW'($urandom_range(0, 3));
            for (int j = 0; j < CW; j++) begin
                cv[j] = ($urandom_range(0, 3) == 0);
                ce[j] = ($urandom_range(0, 9) < 7);
                cw[j*NWW +: NWW] = NWW'($urandom_range(0, 3));
            end
            drive(1'b0, iv, iw, cv, cw, ce);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
